// File: rtl/knight_seq_ctrl.sv
// knight_seq_ctrl
// ----------------------------------------------------------------------------
// Run controller for the knight-flasher LED scanner. It owns the step-rate
// prescaler, start/stop sequencing and sweep direction, and drives a one-hot
// LED bus that bounces 0 -> 7 -> 0 while a run is active.
//
// Optional feature macro: KNIGHT_PAUSE_EN
//   When defined, the scanner dwells PAUSE_STEPS extra ticks at each end of
//   the sweep (states PAUSE_HI / PAUSE_LO). When undefined, reversal is
//   immediate and no pause logic is built.
//
// Parameters:
//   DIV_W        width of the prescaler divisor and counter
//   DEFAULT_DIV  divisor loaded at reset (tick period is DIV+1 cycles)
//   PAUSE_STEPS  extra ticks held at each end (>= 1, used with the macro only)
//
// Ports:
//   ck          clock, all state changes on its rising edge
//   res         synchronous active-high reset
//   start       level, requests a run (cancels a pending stop while busy)
//   stop        level, requests a stop at the end of the current sweep
//   div_we      loads div_in into the divisor and restarts the prescaler
//   div_in      new divisor value
//   out         one-hot LED drive, 1 << pos while busy, else 0
//   pos         current lit position
//   dir         0 = ascending, 1 = descending
//   busy        high in every state except IDLE
//   step        one-cycle pulse aligned with each position / pause advance
//   sweep_done  one-cycle pulse when pos returns to 0
// ----------------------------------------------------------------------------
module knight_seq_ctrl #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 3,
    parameter int unsigned PAUSE_STEPS = 2
) (
    input  logic             ck,
    input  logic             res,
    input  logic             start,
    input  logic             stop,
    input  logic             div_we,
    input  logic [DIV_W-1:0] div_in,
    output logic [7:0]       out,
    output logic [2:0]       pos,
    output logic             dir,
    output logic             busy,
    output logic             step,
    output logic             sweep_done
);

`ifdef KNIGHT_PAUSE_EN
    typedef enum logic [2:0] {
        IDLE,
        RUN_UP,
        RUN_DN,
        PAUSE_HI,
        PAUSE_LO
    } state_t;

    localparam int unsigned PCNT_W = (PAUSE_STEPS > 1) ? $clog2(PAUSE_STEPS) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PAUSE_STEPS - 1);
`else
    typedef enum logic [1:0] {
        IDLE,
        RUN_UP,
        RUN_DN
    } state_t;
`endif

    // A zero dwell length would make the pause states meaningless, so it is
    // rejected when the design is elaborated.
    if (PAUSE_STEPS == 0) begin : g_pause_steps_check
        $error("knight_seq_ctrl: PAUSE_STEPS must be at least 1");
    end

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic [7:0]       out_q, out_d;
    logic             step_q, step_d;
    logic             done_q, done_d;
    logic             stop_pend_q, stop_pend_d;
    logic             tick;
`ifdef KNIGHT_PAUSE_EN
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
`endif

    // Next-state logic. The prescaler only counts while busy; a divisor write
    // restarts counting from zero and suppresses any tick on that same edge,
    // so the next step always lands DIV_new+1 cycles after the write. Output
    // values are computed from the next state so that every output port comes
    // straight from a register and stays aligned with the new position.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        pos_d       = pos_q;
        dir_d       = dir_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
`ifdef KNIGHT_PAUSE_EN
        pcnt_d      = pcnt_q;
`endif

        tick   = busy_q && !div_we && (cnt_q == div_q);
        step_d = tick;

        if (busy_q) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
            if (stop) begin
                stop_pend_d = 1'b1;
            end else if (start) begin
                stop_pend_d = 1'b0;
            end
        end

        if (div_we) begin
            div_d = div_in;
            cnt_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN_UP;
                    pos_d   = 3'd0;
                    dir_d   = 1'b0;
                    cnt_d   = '0;
                end
            end

            RUN_UP: begin
                if (tick) begin
                    pos_d = pos_q + 3'd1;
                    if (pos_q == 3'd6) begin
`ifdef KNIGHT_PAUSE_EN
                        state_d = PAUSE_HI;
`else
                        state_d = RUN_DN;
                        dir_d   = 1'b1;
`endif
                    end
                end
            end

            RUN_DN: begin
                if (tick) begin
                    pos_d = pos_q - 3'd1;
                    if (pos_q == 3'd1) begin
                        done_d = 1'b1;
                        if (stop_pend_q) begin
                            state_d     = IDLE;
                            stop_pend_d = 1'b0;
                        end else begin
`ifdef KNIGHT_PAUSE_EN
                            state_d = PAUSE_LO;
`else
                            state_d = RUN_UP;
                            dir_d   = 1'b0;
`endif
                        end
                    end
                end
            end

`ifdef KNIGHT_PAUSE_EN
            PAUSE_HI: begin
                if (tick) begin
                    if (pcnt_q == PCNT_LAST) begin
                        pcnt_d  = '0;
                        state_d = RUN_DN;
                        dir_d   = 1'b1;
                    end else begin
                        pcnt_d = pcnt_q + PCNT_W'(1);
                    end
                end
            end

            PAUSE_LO: begin
                if (tick) begin
                    if (pcnt_q == PCNT_LAST) begin
                        pcnt_d  = '0;
                        state_d = RUN_UP;
                        dir_d   = 1'b0;
                    end else begin
                        pcnt_d = pcnt_q + PCNT_W'(1);
                    end
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        out_d  = busy_d ? (8'd1 << pos_d) : 8'd0;
    end

    // State and output registers; reset aborts any run on the next edge.
    always_ff @(posedge ck) begin
        if (res) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_q       <= DIV_W'(DEFAULT_DIV);
            pos_q       <= 3'd0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_q       <= 8'd0;
            step_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_pend_q <= 1'b0;
`ifdef KNIGHT_PAUSE_EN
            pcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            busy_q      <= busy_d;
            out_q       <= out_d;
            step_q      <= step_d;
            done_q      <= done_d;
            stop_pend_q <= stop_pend_d;
`ifdef KNIGHT_PAUSE_EN
            pcnt_q      <= pcnt_d;
`endif
        end
    end

    assign out        = out_q;
    assign pos        = pos_q;
    assign dir        = dir_q;
    assign busy       = busy_q;
    assign step       = step_q;
    assign sweep_done = done_q;

endmodule

// File: tb/tb_knight_seq_ctrl.sv
// tb_knight_seq_ctrl
// ----------------------------------------------------------------------------
// Directed testbench for knight_seq_ctrl: reset, full sweep with DIV=3,
// graceful stop, start+stop collision in IDLE, divisor rewrites, stop cancel,
// mid-run reset, and (when KNIGHT_PAUSE_EN is defined) end-of-sweep dwell.
// ----------------------------------------------------------------------------
module tb_knight_seq_ctrl;

    logic        ck = 1'b0;
    logic        res;
    logic        start;
    logic        stop;
    logic        div_we;
    logic [15:0] div_in;
    logic [7:0]  out;
    logic [2:0]  pos;
    logic        dir;
    logic        busy;
    logic        step;
    logic        sweep_done;

    int checks = 0;
    int errors = 0;

    // Expected positions and directions after each tick of one full sweep
    // that starts ascending from position 0 (no pauses).
    int   sweepPos[14] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
    logic sweepDir[14] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};

    knight_seq_ctrl #(
        .DIV_W       (16),
        .DEFAULT_DIV (3),
        .PAUSE_STEPS (2)
    ) dut (
        .ck         (ck),
        .res        (res),
        .start      (start),
        .stop       (stop),
        .div_we     (div_we),
        .div_in     (div_in),
        .out        (out),
        .pos        (pos),
        .dir        (dir),
        .busy       (busy),
        .step       (step),
        .sweep_done (sweep_done)
    );

    // Free-running clock, 10 time units per period.
    always #5 ck = ~ck;

    // Inputs change and outputs are sampled on the falling edge, well away
    // from the rising edge the design uses.
    task automatic waitCycles(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Waits one tick period, confirming no step happens early, then checks
    // the full output set right after the tick edge.
    task automatic stepAndCheck(input string tag, input int period, input int expPos,
                                input logic expDir, input logic expDone);
        if (period > 1) begin
            waitCycles(period - 1);
            checkOutput({tag, "_hold"}, {31'd0, step}, 32'd0);
        end
        waitCycles(1);
        checkOutput({tag, "_pos"},  {29'd0, pos}, expPos);
        checkOutput({tag, "_out"},  {24'd0, out}, 32'd1 << expPos);
        checkOutput({tag, "_dir"},  {31'd0, dir}, {31'd0, expDir});
        checkOutput({tag, "_step"}, {31'd0, step}, 32'd1);
        checkOutput({tag, "_done"}, {31'd0, sweep_done}, {31'd0, expDone});
    endtask

    task automatic applyStimulus(input logic s, input logic p, input int cycles);
        start = s;
        stop  = p;
        waitCycles(cycles);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        res    = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        div_we = 1'b0;
        div_in = '0;

        // Reset state
        waitCycles(2);
        checkOutput("rst_out",  {24'd0, out}, 32'd0);
        checkOutput("rst_pos",  {29'd0, pos}, 32'd0);
        checkOutput("rst_dir",  {31'd0, dir}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_step", {31'd0, step}, 32'd0);
        checkOutput("rst_done", {31'd0, sweep_done}, 32'd0);
        res = 1'b0;

        // Start pulse: out=0x01 right after the sampling edge
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("start_busy", {31'd0, busy}, 32'd1);
        checkOutput("start_out",  {24'd0, out}, 32'h01);
        checkOutput("start_pos",  {29'd0, pos}, 32'd0);
        checkOutput("start_step", {31'd0, step}, 32'd0);

        // One full sweep at DIV=3: a step every 4 cycles, sweep_done after 56
        for (int i = 0; i < 14; i++) begin
            stepAndCheck($sformatf("sweep%0d", i), 4, sweepPos[i], sweepDir[i], i == 13);
        end
        checkOutput("sweep_still_busy", {31'd0, busy}, 32'd1);
        stepAndCheck("cont1", 4, 1, 1'b0, 1'b0);
        stepAndCheck("cont2", 4, 2, 1'b0, 1'b0);
        stepAndCheck("cont3", 4, 3, 1'b0, 1'b0);

        // Graceful stop requested at pos 3 ascending
        applyStimulus(1'b0, 1'b1, 1);
        stepAndCheck("stop4", 3, 4, 1'b0, 1'b0);
        for (int i = 4; i < 13; i++) begin
            stepAndCheck($sformatf("stop_sweep%0d", i), 4, sweepPos[i], sweepDir[i], 1'b0);
        end
        waitCycles(3);
        checkOutput("stop_end_hold_busy", {31'd0, busy}, 32'd1);
        waitCycles(1);
        checkOutput("stop_end_done", {31'd0, sweep_done}, 32'd1);
        checkOutput("stop_end_busy", {31'd0, busy}, 32'd0);
        checkOutput("stop_end_out",  {24'd0, out}, 32'd0);
        checkOutput("stop_end_pos",  {29'd0, pos}, 32'd0);
        checkOutput("stop_end_step", {31'd0, step}, 32'd1);
        waitCycles(5);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("idle_out",  {24'd0, out}, 32'd0);
        checkOutput("idle_step", {31'd0, step}, 32'd0);

        // start and stop together in IDLE: stop wins
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("collide_busy", {31'd0, busy}, 32'd0);
        checkOutput("collide_out",  {24'd0, out}, 32'd0);
        waitCycles(1);
        checkOutput("collide_busy2", {31'd0, busy}, 32'd0);

        // Divisor write to 0 mid-run, then to 7
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("div_start_busy", {31'd0, busy}, 32'd1);
        waitCycles(2);
        div_we = 1'b1;
        div_in = 16'd0;
        waitCycles(1);
        div_we = 1'b0;
        checkOutput("div0_wr_pos",  {29'd0, pos}, 32'd0);
        checkOutput("div0_wr_step", {31'd0, step}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            stepAndCheck($sformatf("fast%0d", i), 1, sweepPos[i], sweepDir[i], 1'b0);
        end
        div_we = 1'b1;
        div_in = 16'd7;
        waitCycles(1);
        div_we = 1'b0;
        checkOutput("div7_wr_pos",  {29'd0, pos}, 32'd4);
        checkOutput("div7_wr_step", {31'd0, step}, 32'd0);
        stepAndCheck("slow5", 8, 5, 1'b0, 1'b0);
        stepAndCheck("slow6", 8, 6, 1'b0, 1'b0);

        // Stop then start while busy: the stop is cancelled
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1);
        stepAndCheck("cancel7", 6, 7, 1'b1, 1'b0);
        for (int i = 7; i < 14; i++) begin
            stepAndCheck($sformatf("cancel%0d", i), 8, sweepPos[i], sweepDir[i], i == 13);
        end
        checkOutput("cancel_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            stepAndCheck($sformatf("cancel_cont%0d", i), 8, sweepPos[i], sweepDir[i], 1'b0);
        end

        // Reset mid-run at pos 5
        res = 1'b1;
        waitCycles(1);
        checkOutput("midrst_out",  {24'd0, out}, 32'd0);
        checkOutput("midrst_pos",  {29'd0, pos}, 32'd0);
        checkOutput("midrst_dir",  {31'd0, dir}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_step", {31'd0, step}, 32'd0);
        waitCycles(1);
        res = 1'b0;
        // Divisor back to 3: first step 4 cycles after start
        applyStimulus(1'b1, 1'b0, 1);
        stepAndCheck("postrst1", 4, 1, 1'b0, 1'b0);

`ifdef KNIGHT_PAUSE_EN
        // Dwell at both ends with DIV=0 and PAUSE_STEPS=2
        begin
            int   pausePos[19] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0, 1};
            logic pauseDir[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
            res = 1'b1;
            waitCycles(2);
            res    = 1'b0;
            div_we = 1'b1;
            div_in = 16'd0;
            waitCycles(1);
            div_we = 1'b0;
            applyStimulus(1'b1, 1'b0, 1);
            for (int i = 0; i < 19; i++) begin
                stepAndCheck($sformatf("pause%0d", i), 1, pausePos[i], pauseDir[i], i == 15);
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
